// File: rtl/log2_rr_scheduler.sv
// log2_rr_scheduler: round-robin share of one combinational Q-format log2 unit across NUM_REQ requesters.
// Optional LOG2_SCHED_ZERO_ERR_EN: zero operand yields most-negative result with res_err=1.
module log2_rr_scheduler #(
    parameter int NUM_REQ         = 4,
    parameter int FIX_POINT_WIDTH = 16,
    parameter int Bf              = 8,
    parameter int ID_W            = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*FIX_POINT_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic                               res_valid,
    input  logic                               res_ready,
    output logic [FIX_POINT_WIDTH-1:0]         res_data,
    output logic [ID_W-1:0]                    res_id,
    output logic                               res_err
);
    localparam int W = FIX_POINT_WIDTH;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t          state, state_nx;
    logic [ID_W-1:0] ptr, ptr_nx, winner;
    logic            slot_free, grant;
    logic [W-1:0]    operand, log2_out, result;
    logic [Bf-1:0]   frac;
    logic            err;
    int              idx, msb;

    // Descending scan so the candidate closest to ptr is assigned last and wins.
    always_comb begin
        winner = ptr;
        idx = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req_valid[idx]) winner = ID_W'(idx);
        end
    end

    assign slot_free = (state == EMPTY) || res_ready;
    assign grant     = slot_free && (|req_valid) && !rst;
    assign req_ready = grant ? (NUM_REQ'(1) << winner) : '0;
    assign operand   = req_data[int'(winner)*W +: W];

    // Mitchell log2: integer part is the leading-one position minus Bf, fraction is the
    // linearly interpolated mantissa below that leading one (truncated).
    always_comb begin
        msb = 0;
        for (int i = 0; i < W; i++)
            if (operand[i]) msb = i;
        frac = Bf'({operand, {Bf{1'b0}}} >> msb);
        log2_out = W'((msb - Bf) * (1 << Bf)) + W'(frac);
    end

`ifdef LOG2_SCHED_ZERO_ERR_EN
    assign err    = (operand == '0);
    assign result = err ? {1'b1, {(W-1){1'b0}}} : log2_out;
`else
    assign err    = 1'b0;
    assign result = log2_out;
`endif

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        if (grant) begin
            state_nx = FULL;
            ptr_nx   = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        end else if (state == FULL && res_ready) begin
            state_nx = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            ptr      <= '0;
            res_data <= '0;
            res_id   <= '0;
            res_err  <= 1'b0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            if (grant) begin
                res_data <= result;
                res_id   <= winner;
                res_err  <= err;
            end
        end
    end

    assign res_valid = (state == FULL);
endmodule

// File: tb/tb_log2_rr_scheduler.sv
// tb_log2_rr_scheduler: directed scenarios plus randomized traffic against a behavioural scoreboard.
module tb_log2_rr_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [1:0]  res_id;
    logic        res_err;
    int          errors = 0;
    int          checks = 0;

    log2_rr_scheduler #(.NUM_REQ(4), .FIX_POINT_WIDTH(16), .Bf(8), .ID_W(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id), .res_err(res_err)
    );

    always #5 clk = ~clk;

    // Reference log2: floor(log2 x) as integer part, linear interpolation between powers of two as fraction.
    function automatic logic [15:0] ref_log2(input logic [15:0] x);
        int p, frac, v;
        if (x == 0) begin
`ifdef LOG2_SCHED_ZERO_ERR_EN
            return 16'h8000;
`else
            return 16'hF800;
`endif
        end
        p = 0;
        for (int i = 0; i < 16; i++)
            if (int'(x) >= (1 << i)) p = i;
        frac = ((int'(x) - (1 << p)) * 256) / (1 << p);
        v = (p - 8) * 256 + frac;
        return v[15:0];
    endfunction

    function automatic logic ref_err(input logic [15:0] x);
`ifdef LOG2_SCHED_ZERO_ERR_EN
        return x == 0;
`else
        return 1'b0 && (x == 0);
`endif
    endfunction

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = '0; res_ready = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'hF; req_data = 64'h0800_0400_0200_0100; res_ready = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            #1;
            checks++;
            if (req_ready !== 4'b0 || res_valid !== 1'b0 || res_data !== 16'h0 || res_id !== 2'd0 || res_err !== 1'b0) begin
                errors++;
                $display("FAIL reset: ready=%b valid=%b data=%h id=%0d err=%b, want 0 0 0000 0 0", req_ready, res_valid, res_data, res_id, res_err);
            end
        end
    endtask

    task automatic test_single();
        next_cycle();
        rst = 1'b0; req_valid = 4'b0100; req_data = '0; req_data[32 +: 16] = 16'h0400; res_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_grant: got %b want 0100", req_ready);
        end
        next_cycle();
        req_valid = '0;
        #1;
        checks++;
        if (res_valid !== 1'b1 || res_data !== 16'h0200 || res_id !== 2'd2 || res_err !== 1'b0) begin
            errors++;
            $display("FAIL single_result: valid=%b data=%h id=%0d err=%b want 1 0200 2 0", res_valid, res_data, res_id, res_err);
        end
        next_cycle();
        #1;
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: res_valid=%b want 0", res_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] exp_d [4] = '{16'h0000, 16'h0100, 16'h0200, 16'h0300};
        apply_reset();
        req_valid = 4'hF; req_data = 64'h0800_0400_0200_0100; res_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            #1;
            checks++;
            if (req_ready !== 4'(1 << (k % 4))) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, 4'(1 << (k % 4)));
            end
            if (k > 0) begin
                checks++;
                if (res_valid !== 1'b1 || res_id !== 2'((k - 1) % 4) || res_data !== exp_d[(k - 1) % 4]) begin
                    errors++;
                    $display("FAIL rr_result[%0d]: valid=%b id=%0d data=%h want 1 %0d %h", k, res_valid, res_id, res_data, (k - 1) % 4, exp_d[(k - 1) % 4]);
                end
            end
            next_cycle();
        end
        req_valid = '0;
        next_cycle();
    endtask

    task automatic test_backpressure();
        apply_reset();
        req_valid = 4'hF; req_data = 64'h0800_0500_0280_0300; res_ready = 1'b1;
        next_cycle();
        res_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (req_ready !== 4'b0 || res_valid !== 1'b1 || res_id !== 2'd0 || res_data !== ref_log2(16'h0300)) begin
                errors++;
                $display("FAIL backpressure[%0d]: ready=%b valid=%b id=%0d data=%h want 0000 1 0 %h", c, req_ready, res_valid, res_id, res_data, ref_log2(16'h0300));
            end
            next_cycle();
        end
        res_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_release_grant: got %b want 0010", req_ready);
        end
        next_cycle();
        req_valid = '0;
        #1;
        checks++;
        if (res_valid !== 1'b1 || res_id !== 2'd1 || res_data !== ref_log2(16'h0280)) begin
            errors++;
            $display("FAIL bp_release_result: valid=%b id=%0d data=%h want 1 1 %h", res_valid, res_id, res_data, ref_log2(16'h0280));
        end
        next_cycle();
    endtask

    task automatic test_zero();
        apply_reset();
        req_valid = 4'b0010; req_data = '0; res_ready = 1'b1;
        next_cycle();
        req_data[16 +: 16] = 16'h0100;
        #1;
        checks++;
        if (res_valid !== 1'b1 || res_data !== ref_log2(16'h0) || res_err !== ref_err(16'h0) || res_id !== 2'd1) begin
            errors++;
            $display("FAIL zero_operand: data=%h err=%b id=%0d want %h %b 1", res_data, res_err, res_id, ref_log2(16'h0), ref_err(16'h0));
        end
        next_cycle();
        req_valid = '0;
        #1;
        checks++;
        if (res_valid !== 1'b1 || res_data !== 16'h0000 || res_err !== 1'b0) begin
            errors++;
            $display("FAIL zero_follow: data=%h err=%b want 0000 0", res_data, res_err);
        end
        next_cycle();
    endtask

    task automatic test_reset_midflight();
        req_valid = 4'hF; req_data = 64'h0800_0400_0200_0100; res_ready = 1'b0;
        next_cycle();
        #1;
        checks++;
        if (res_valid !== 1'b1 || res_id !== 2'd2) begin
            errors++;
            $display("FAIL midflight_setup: valid=%b id=%0d want 1 2", res_valid, res_id);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0) begin
            errors++;
            $display("FAIL midflight_rst_grant: got %b want 0000", req_ready);
        end
        next_cycle();
        rst = 1'b0; res_ready = 1'b1;
        #1;
        checks++;
        if (res_valid !== 1'b0 || res_data !== 16'h0 || req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL midflight_after: valid=%b data=%h ready=%b want 0 0000 0001", res_valid, res_data, req_ready);
        end
        next_cycle();
        req_valid = '0;
        next_cycle();
    endtask

    task automatic test_random();
        logic        mv = 1'b0, merr = 1'b0;
        logic [15:0] mdata = '0;
        int          mid = 0, mptr = 0, w;
        logic [3:0]  exp_ready, pending = '0;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pending[i]) begin
                    req_valid[i] = ($urandom_range(0, 9) < 6);
                    req_data[i*16 +: 16] = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
                end
            end
            res_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_ready = '0;
            w = -1;
            if ((!mv || res_ready) && (|req_valid))
                for (int k = 0; k < 4; k++)
                    if (w < 0 && req_valid[(mptr + k) % 4]) w = (mptr + k) % 4;
            if (w >= 0) exp_ready[w] = 1'b1;
            checks++;
            if (req_ready !== exp_ready) begin
                errors++;
                $display("FAIL rand_grant[%0d]: got %b want %b", c, req_ready, exp_ready);
            end
            checks++;
            if (res_valid !== mv || (mv && (res_data !== mdata || res_id !== 2'(mid) || res_err !== merr))) begin
                errors++;
                $display("FAIL rand_result[%0d]: valid=%b data=%h id=%0d err=%b want %b %h %0d %b", c, res_valid, res_data, res_id, res_err, mv, mdata, mid, merr);
            end
            if (w >= 0) begin
                mv = 1'b1; mdata = ref_log2(req_data[w*16 +: 16]); merr = ref_err(req_data[w*16 +: 16]);
                mid = w; mptr = (w + 1) % 4;
            end else if (mv && res_ready) begin
                mv = 1'b0;
            end
            pending = req_valid & ~exp_ready;
            next_cycle();
        end
        req_valid = '0;
    endtask

    initial begin
        fork
            begin
                #2000000;
                $display("FAIL timeout: simulation exceeded time limit");
                $fatal(1, "timeout");
            end
        join_none
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_zero();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
